ri5cy_ahb_arbiter: RTL and testbench



---
 rtl/ri5cy_ahb_arbiter_pkg.sv | 32 +++
 rtl/ri5cy_ahb_arbiter_if.sv | 52 +++++
 rtl/ri5cy_ahb_arbiter_rr_arb2.sv | 24 ++
 rtl/ri5cy_ahb_arbiter.sv | 77 +++++++
 tb/tb_ri5cy_ahb_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ri5cy_ahb_arbiter_pkg.sv
// ri5cy_ahb_pkg: shared AHB encodings, arbiter state/owner types and byte-enable decode
package ri5cy_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic {IDLE, DPHASE} arb_state_t;
    typedef enum logic {INSTR, DATA} owner_t;

    typedef struct packed {
        logic [2:0] size;
        logic [1:0] off;
    } size_off_t;

    // Unsupported byte-enable patterns fall back to an aligned word access
    function automatic size_off_t be_to_size(input logic [3:0] be);
        case (be)
            4'b0011: return '{size: HSIZE_HALF, off: 2'd0};
            4'b1100: return '{size: HSIZE_HALF, off: 2'd2};
            4'b0001: return '{size: HSIZE_BYTE, off: 2'd0};
            4'b0010: return '{size: HSIZE_BYTE, off: 2'd1};
            4'b0100: return '{size: HSIZE_BYTE, off: 2'd2};
            4'b1000: return '{size: HSIZE_BYTE, off: 2'd3};
            default: return '{size: HSIZE_WORD, off: 2'd0};
        endcase
    endfunction

endpackage

// File: rtl/ri5cy_ahb_arbiter_if.sv
// ri5cy_ahb_arbiter_if: RI5CY instr/data req-gnt-rvalid ports plus the shared AHB-Lite master port
interface ri5cy_ahb_arbiter_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
);
    logic                      instr_req_i;
    logic [AHB_ADDR_WIDTH-1:0] instr_addr_i;
    logic                      instr_gnt_o;
    logic                      instr_rvalid_o;
    logic [31:0]               instr_rdata_o;
    logic                      instr_err_o;
    logic                      data_req_i;
    logic                      data_we_i;
    logic [3:0]                data_be_i;
    logic [AHB_ADDR_WIDTH-1:0] data_addr_i;
    logic [31:0]               data_wdata_i;
    logic                      data_gnt_o;
    logic                      data_rvalid_o;
    logic [31:0]               data_rdata_o;
    logic                      data_err_o;
    logic [AHB_ADDR_WIDTH-1:0] haddr_o;
    logic [AHB_DATA_WIDTH-1:0] hwdata_o;
    logic                      hwrite_o;
    logic [2:0]                hsize_o;
    logic [2:0]                hburst_o;
    logic [3:0]                hprot_o;
    logic [1:0]                htrans_o;
    logic                      hmastlock_o;
    logic                      hsel_o;
    logic                      hready_o;
    logic [AHB_DATA_WIDTH-1:0] hrdata_i;
    logic                      hreadyout_i;
    logic                      hresp_i;

    modport master (
        input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i,
               data_wdata_i, hrdata_i, hreadyout_i, hresp_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
               data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
               haddr_o, hwdata_o, hwrite_o, hsize_o, hburst_o, hprot_o, htrans_o,
               hmastlock_o, hsel_o, hready_o
    );

    modport slave (
        output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i,
               data_wdata_i, hrdata_i, hreadyout_i, hresp_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
               data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
               haddr_o, hwdata_o, hwrite_o, hsize_o, hburst_o, hprot_o, htrans_o,
               hmastlock_o, hsel_o, hready_o
    );
endinterface

// File: rtl/ri5cy_ahb_arbiter_rr_arb2.sv
// ri5cy_rr_arb2: two-way instr/data arbiter, round-robin on last winner or fixed data priority
module ri5cy_rr_arb2
    import ri5cy_ahb_pkg::*;
#(
    parameter bit ARB_RR = 1'b1
) (
    input  logic   clk_i,
    input  logic   rstn_i,
    input  logic   req_instr_i,
    input  logic   req_data_i,
    input  logic   advance_i,
    output owner_t winner_o
);
    owner_t last_q, last_d;

    assign winner_o = (ARB_RR && req_instr_i && req_data_i)
                      ? ((last_q == INSTR) ? DATA : INSTR)
                      : (req_data_i ? DATA : INSTR);
    assign last_d   = advance_i ? winner_o : last_q;

    always_ff @(posedge clk_i) begin
        last_q <= rstn_i ? last_d : INSTR;
    end
endmodule

// File: rtl/ri5cy_ahb_arbiter.sv
// ri5cy_ahb_arbiter: non-pipelined sharing of one AHB-Lite master port by the RI5CY instr and data ports
module ri5cy_ahb_arbiter
    import ri5cy_ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter bit ARB_RR         = 1'b1
) (
    input logic                 core_clk,
    input logic                 core_rstn,
    ri5cy_ahb_arbiter_if.master bus
);
    arb_state_t                state_q;
    owner_t                    owner_q, winner;
    logic                      we_q;
    logic [AHB_DATA_WIDTH-1:0] wdata_q;
    logic                      addr_phase, grant, resp, win_data;
    size_off_t                 so;
    logic [AHB_ADDR_WIDTH-1:0] data_haddr, instr_haddr;

    ri5cy_rr_arb2 #(.ARB_RR(ARB_RR)) u_arb (
        .clk_i      (core_clk),
        .rstn_i     (core_rstn),
        .req_instr_i(bus.instr_req_i),
        .req_data_i (bus.data_req_i),
        .advance_i  (grant),
        .winner_o   (winner)
    );

    // Outputs are masked while reset is held so nothing escapes during the reset cycle
    assign addr_phase  = core_rstn && state_q == IDLE && (bus.instr_req_i || bus.data_req_i);
    assign grant       = addr_phase && bus.hreadyout_i;
    assign resp        = core_rstn && state_q == DPHASE && bus.hreadyout_i;
    assign win_data    = addr_phase && winner == DATA;
    assign so          = be_to_size(bus.data_be_i);
    assign data_haddr  = {bus.data_addr_i[AHB_ADDR_WIDTH-1:2], so.off};
    assign instr_haddr = {bus.instr_addr_i[AHB_ADDR_WIDTH-1:2], 2'b00};

    assign bus.htrans_o    = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.hsel_o      = addr_phase;
    assign bus.haddr_o     = !addr_phase ? '0 : win_data ? data_haddr : instr_haddr;
    assign bus.hsize_o     = win_data ? so.size : HSIZE_WORD;
    assign bus.hwrite_o    = win_data && bus.data_we_i;
    assign bus.hprot_o     = {3'b000, win_data};
    assign bus.hburst_o    = HBURST_SINGLE;
    assign bus.hmastlock_o = 1'b0;
    assign bus.hready_o    = bus.hreadyout_i;
    assign bus.hwdata_o    = wdata_q;

    assign bus.instr_gnt_o    = grant && winner == INSTR;
    assign bus.data_gnt_o     = grant && winner == DATA;
    assign bus.instr_rvalid_o = resp && owner_q == INSTR;
    assign bus.data_rvalid_o  = resp && owner_q == DATA;
    assign bus.instr_rdata_o  = bus.instr_rvalid_o ? bus.hrdata_i : '0;
    assign bus.data_rdata_o   = bus.data_rvalid_o ? bus.hrdata_i : '0;
    assign bus.instr_err_o    = bus.instr_rvalid_o && bus.hresp_i;
    assign bus.data_err_o     = bus.data_rvalid_o && bus.hresp_i;

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            state_q <= IDLE;
            owner_q <= INSTR;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= grant ? DPHASE : resp ? IDLE : state_q;
            if (grant) begin
                owner_q <= winner;
                we_q    <= winner == DATA && bus.data_we_i;
                wdata_q <= winner == DATA ? bus.data_wdata_i : '0;
            end
        end
    end

    logic unused_we;
    assign unused_we = we_q;
endmodule

// File: tb/tb_ri5cy_ahb_arbiter.sv
// tb_ri5cy_ahb_arbiter: directed checks of the instr/data AHB arbiter (round-robin and fixed-priority builds)
module tb_ri5cy_ahb_arbiter;
    logic core_clk = 1'b0;
    logic core_rstn;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 core_clk = ~core_clk;

    ri5cy_ahb_arbiter_if bus ();
    ri5cy_ahb_arbiter_if bus_fp ();

    ri5cy_ahb_arbiter #(.ARB_RR(1'b1)) dut (.core_clk(core_clk), .core_rstn(core_rstn), .bus(bus.master));
    ri5cy_ahb_arbiter #(.ARB_RR(1'b0)) dut_fp (.core_clk(core_clk), .core_rstn(core_rstn), .bus(bus_fp.master));

    assign bus_fp.instr_req_i  = bus.instr_req_i;
    assign bus_fp.instr_addr_i = bus.instr_addr_i;
    assign bus_fp.data_req_i   = bus.data_req_i;
    assign bus_fp.data_we_i    = bus.data_we_i;
    assign bus_fp.data_be_i    = bus.data_be_i;
    assign bus_fp.data_addr_i  = bus.data_addr_i;
    assign bus_fp.data_wdata_i = bus.data_wdata_i;
    assign bus_fp.hrdata_i     = bus.hrdata_i;
    assign bus_fp.hreadyout_i  = bus.hreadyout_i;
    assign bus_fp.hresp_i      = bus.hresp_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge core_clk);
        #1;
    endtask

    logic [3:0]  be_tab   [5] = '{4'b1100, 4'b0011, 4'b0101, 4'b1000, 4'b0000};
    logic [31:0] addr_tab [5] = '{32'h2002, 32'h2000, 32'h2000, 32'h2003, 32'h2000};
    logic [2:0]  size_tab [5] = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd2};

    initial begin
        core_rstn = 1'b0;
        bus.instr_req_i = 0; bus.instr_addr_i = 0; bus.data_req_i = 0; bus.data_we_i = 0;
        bus.data_be_i = 4'hF; bus.data_addr_i = 0; bus.data_wdata_i = 0;
        bus.hrdata_i = 0; bus.hreadyout_i = 1; bus.hresp_i = 0;
        cyc(); cyc();
        chk("rst_htrans", 32'(bus.htrans_o), 0);
        chk("rst_hsel", 32'(bus.hsel_o), 0);
        chk("rst_haddr", bus.haddr_o, 0);
        chk("rst_hwdata", bus.hwdata_o, 0);
        chk("rst_hsize", 32'(bus.hsize_o), 2);
        chk("rst_gnt", {bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o}, 0);
        core_rstn = 1'b1;

        // lone instruction read
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h100; bus.hrdata_i = 32'hDEADBEEF;
        #1;
        chk("i_gnt", {bus.instr_gnt_o, bus.data_gnt_o}, 2'b10);
        chk("i_haddr", bus.haddr_o, 32'h100);
        chk("i_htrans", 32'(bus.htrans_o), 2);
        chk("i_hsel", 32'(bus.hsel_o), 1);
        chk("i_hprot", 32'(bus.hprot_o), 0);
        cyc(); bus.instr_req_i = 0; #1;
        chk("i_rvalid", {bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o}, 3'b100);
        chk("i_rdata", bus.instr_rdata_o, 32'hDEADBEEF);
        chk("i_dph_htrans", 32'(bus.htrans_o), 0);
        cyc();
        chk("i_rvalid_once", 32'(bus.instr_rvalid_o), 0);

        // both ports requesting continuously
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h200;
        bus.data_req_i = 1; bus.data_addr_i = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_gnt%0d", i), {bus.data_gnt_o, bus.instr_gnt_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("fp_gnt%0d", i), {bus_fp.data_gnt_o, bus_fp.instr_gnt_o}, 2'b10);
            cyc();
            chk($sformatf("rr_rv%0d", i), {bus.data_rvalid_o, bus.instr_rvalid_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("fp_rv%0d", i), {bus_fp.data_rvalid_o, bus_fp.instr_rvalid_o}, 2'b10);
            chk($sformatf("rr_nognt%0d", i), {bus.data_gnt_o, bus.instr_gnt_o}, 2'b00);
            cyc();
        end
        bus.instr_req_i = 0; bus.data_req_i = 0;

        // byte write
        bus.data_req_i = 1; bus.data_we_i = 1; bus.data_be_i = 4'b0100;
        bus.data_addr_i = 32'h2000; bus.data_wdata_i = 32'h00AB0000;
        #1;
        chk("w_gnt", 32'(bus.data_gnt_o), 1);
        chk("w_haddr", bus.haddr_o, 32'h2002);
        chk("w_hsize", 32'(bus.hsize_o), 0);
        chk("w_hwrite", 32'(bus.hwrite_o), 1);
        chk("w_hprot", 32'(bus.hprot_o), 1);
        cyc(); bus.data_req_i = 0; bus.data_we_i = 0; bus.data_wdata_i = 0; #1;
        chk("w_hwdata", bus.hwdata_o, 32'h00AB0000);
        chk("w_rvalid", 32'(bus.data_rvalid_o), 1);
        cyc();

        // size/offset decode, observed while the slave is not ready so no grant happens
        bus.hreadyout_i = 0; bus.data_req_i = 1;
        for (int i = 0; i < 5; i++) begin
            bus.data_be_i = be_tab[i];
            #1;
            chk($sformatf("be%0d_haddr", i), bus.haddr_o, addr_tab[i]);
            chk($sformatf("be%0d_hsize", i), 32'(bus.hsize_o), 32'(size_tab[i]));
            chk($sformatf("be%0d_gnt", i), 32'(bus.data_gnt_o), 0);
            cyc();
        end
        chk("hready_mirror", 32'(bus.hready_o), 0);

        // read with three wait states, instr waiting behind it
        bus.hreadyout_i = 1; bus.data_be_i = 4'hF; bus.data_addr_i = 32'h4000;
        #1;
        chk("st_gnt", 32'(bus.data_gnt_o), 1);
        cyc(); bus.data_req_i = 0; bus.instr_req_i = 1; bus.instr_addr_i = 32'h400; bus.hreadyout_i = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("st_frozen%0d", k),
                {bus.data_rvalid_o, bus.instr_gnt_o, bus.instr_rvalid_o, bus.hsel_o, 28'(bus.htrans_o)}, 0);
            cyc();
        end
        bus.hreadyout_i = 1; bus.hrdata_i = 32'h12345678;
        #1;
        chk("st_rvalid", 32'(bus.data_rvalid_o), 1);
        chk("st_rdata", bus.data_rdata_o, 32'h12345678);
        chk("st_nognt", 32'(bus.instr_gnt_o), 0);
        cyc();
        chk("st_next_gnt", 32'(bus.instr_gnt_o), 1);
        chk("st_next_haddr", bus.haddr_o, 32'h400);
        cyc(); bus.instr_req_i = 0; #1;
        chk("st_next_rv", 32'(bus.instr_rvalid_o), 1);
        cyc();

        // error response
        bus.data_req_i = 1; bus.data_addr_i = 32'h5000;
        #1;
        chk("er_gnt", 32'(bus.data_gnt_o), 1);
        cyc(); bus.data_req_i = 0; bus.hresp_i = 1; #1;
        chk("er_rv_err", {bus.data_rvalid_o, bus.data_err_o}, 2'b11);
        cyc(); bus.hresp_i = 0; bus.data_req_i = 1; #1;
        chk("er_regnt", 32'(bus.data_gnt_o), 1);
        cyc(); bus.data_req_i = 0; #1;
        chk("er_rv_ok", {bus.data_rvalid_o, bus.data_err_o}, 2'b10);
        cyc();

        // reset in the data phase
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h300;
        #1;
        chk("rs_gnt", 32'(bus.instr_gnt_o), 1);
        cyc(); core_rstn = 0; #1;
        chk("rs_hold_rv", 32'(bus.instr_rvalid_o), 0);
        cyc();
        chk("rs_after", {bus.instr_rvalid_o, bus.instr_gnt_o, bus.hsel_o, 29'(bus.htrans_o)}, 0);
        core_rstn = 1; #1;
        chk("rs_regnt", 32'(bus.instr_gnt_o), 1);
        chk("rs_haddr", bus.haddr_o, 32'h300);
        cyc(); bus.instr_req_i = 0; #1;
        chk("rs_rv", 32'(bus.instr_rvalid_o), 1);
        cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
